rect_grid_store: RTL
====================

RECT_GRID_STORE -- requirements
Module: rect_grid_store

Interface
REQ-001 The module SHALL have parameter GRID_SIZE_X, default 32, giving the grid width in cells.
REQ-002 The module SHALL have parameter GRID_SIZE_Y, default 24, giving the grid height in cells.
REQ-003 The module SHALL have parameter RECT_SIZE, default 32, giving the cell edge in pixels.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The module SHALL have port rect_write, input, 36 bits: {x[35:20], y[19:4], func[3:0]} cell write command, level-held.
REQ-007 The module SHALL have port rect_read_out, input, 32 bits: {x[31:16], y[15:0]} cell read address.
REQ-008 The module SHALL have port rect_read_in, output, 4 bits: the function of the addressed cell.
REQ-009 The module SHALL have port vga_hcount, input, 11 bits: display pixel x.
REQ-010 The module SHALL have port vga_vcount, input, 11 bits: display pixel y.
REQ-011 The module SHALL have port cell_func, output, 4 bits: the function of the cell under the display pixel.
REQ-012 The module SHALL have port grid_ready, output, 1 bit: high when the clear sweep is done.
REQ-013 The module SHALL have port oob_cnt, output, 8 bits: saturating count of dropped out-of-range writes.

Function
REQ-014 Storage SHALL be GRID_SIZE_X*GRID_SIZE_Y 4-bit cells, with address = y*GRID_SIZE_X + x.
REQ-015 Cell codes SHALL be NULL=4'b0000, SNAKE=4'b0001, ROCK=4'b0010, SNACK=4'b0100; other codes are stored unmodified.
REQ-016 A coordinate pair SHALL be in range only when x<GRID_SIZE_X and y<GRID_SIZE_Y, comparing all 16 bits of each.
REQ-017 The FSM SHALL have state CLEAR: sweep address 0..N-1, one cell per cycle, writing the clear value; after the last address go to RUN.
REQ-018 The FSM SHALL have state RUN: process commands every cycle; it is left only by reset.
REQ-019 grid_ready SHALL be 0 in CLEAR and 1 in RUN, registered; it rises exactly N+1 cycles after rst is released.
REQ-020 In RUN, each cycle with rect_write in range SHALL write func to the cell; a repeated identical command rewrites harmlessly.
REQ-021 In RUN, a cycle with rect_write out of range SHALL drop the write and increment oob_cnt, saturating at 255.
REQ-022 In CLEAR, rect_write SHALL be ignored and SHALL NOT count toward oob_cnt.
REQ-023 rect_read_in SHALL be registered with one cycle of latency from rect_read_out.
REQ-024 A read and a write to the same cell in the same cycle SHALL return the new func (write-first).
REQ-025 An out-of-range read SHALL return ROCK, so that walls are implicit.
REQ-026 A read in CLEAR SHALL return NULL.
REQ-027 The display port SHALL compute cell x = vga_hcount/RECT_SIZE and y = vga_vcount/RECT_SIZE.
REQ-028 cell_func SHALL be registered with one cycle of latency.
REQ-029 cell_func SHALL be NULL when vga_hcount ≥ GRID_SIZE_X*RECT_SIZE, when vga_vcount ≥ GRID_SIZE_Y*RECT_SIZE, or in CLEAR.
REQ-030 The display port SHALL be read-only and independent of the command read port, with no stall or arbitration.

Reset
REQ-031 When rst=0 at a clock edge, the module SHALL set rect_read_in=0, cell_func=0, grid_ready=0, oob_cnt=0, sweep address=0 and state=CLEAR.
REQ-032 Cell contents SHALL NOT be reset directly; the CLEAR sweep initializes them.
REQ-033 A reset asserted mid-sweep or in RUN SHALL restart the sweep from address 0.

Configuration
REQ-034 Macro RECT_GRID_BORDER_EN defined: the clear value SHALL be ROCK for cells with x=0, x=GRID_SIZE_X-1, y=0 or y=GRID_SIZE_Y-1, and NULL elsewhere.
REQ-035 Macro RECT_GRID_BORDER_EN undefined: every cell SHALL clear to NULL.
REQ-036 Sweep length and timing SHALL be the same whether or not RECT_GRID_BORDER_EN is defined.

Structure
REQ-037 Package rect_grid_pkg SHALL hold GRID_SIZE_X, GRID_SIZE_Y, RECT_SIZE, the cell codes and the FSM state encoding.
REQ-038 Sub-module rect_grid_addr SHALL perform the combinational x/y range check and address calculation.
REQ-039 rect_grid_addr SHALL be instantiated for the write path and for the read path.
REQ-040 The display path SHALL use its own shift-based divider.

Verification
REQ-041 Scenario: release rst, hold rect_write in range -> grid_ready rises at cycle 769; no cell changes during the sweep; oob_cnt=0.
REQ-042 Scenario: rect_write={16'd15,16'd15,SNAKE}, then read {15,15} -> rect_read_in=SNAKE one cycle later; read {16,15} -> NULL.
REQ-043 Scenario: same-cycle write {3,4,SNACK} and read {3,4} -> SNACK on the next cycle.
REQ-044 Scenario: write {32,0,SNAKE} for 300 cycles -> oob_cnt=255, no cell changes; read {0,24} -> ROCK.
REQ-045 Scenario: hcount=100, vcount=70 after writing {3,2,SNACK} -> cell_func=SNACK; hcount=1030 -> NULL.
REQ-046 Scenario: RECT_GRID_BORDER_EN defined, reset asserted at sweep address 400 -> sweep restarts; after ready, {0,5}=ROCK and {5,5}=NULL.

Source files
------------

// File: rtl/rect_grid_pkg.sv
// Shared constants for the rectangular cell grid: default geometry, cell
// function codes and the controller state encoding.
package rect_grid_pkg;

  localparam int GRID_SIZE_X = 32;
  localparam int GRID_SIZE_Y = 24;
  localparam int RECT_SIZE   = 32;

  localparam logic [3:0] CELL_NULL  = 4'b0000;
  localparam logic [3:0] CELL_SNAKE = 4'b0001;
  localparam logic [3:0] CELL_ROCK  = 4'b0010;
  localparam logic [3:0] CELL_SNACK = 4'b0100;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/rect_grid_addr.sv
// Combinational coordinate check and flat address: in range only when the
// full 16-bit x and y are below the grid size; address = y*GX + x.
module rect_grid_addr
  import rect_grid_pkg::*;
#(
  parameter int GX = rect_grid_pkg::GRID_SIZE_X,
  parameter int GY = rect_grid_pkg::GRID_SIZE_Y,
  parameter int AW = 10
) (
  input  logic [15:0]   i_x,
  input  logic [15:0]   i_y,
  output logic          o_in_range,
  output logic [AW-1:0] o_addr
);

  localparam int XW = (GX > 1) ? $clog2(GX) : 1;
  localparam int YW = (GY > 1) ? $clog2(GY) : 1;
  localparam logic [16:0] GX_LIM = 17'(GX);
  localparam logic [16:0] GY_LIM = 17'(GY);

  // Only the low coordinate bits feed the address; the upper bits matter
  // solely through the range check, which gates every use of the address.
  assign o_in_range = ({1'b0, i_x} < GX_LIM) && ({1'b0, i_y} < GY_LIM);
  assign o_addr     = AW'(i_y[YW-1:0]) * AW'(GX) + AW'(i_x[XW-1:0]);

endmodule

// File: rtl/rect_grid_store.sv
// Cell grid store for a tile-based game display.
// After reset a sweep writes the clear value into every cell (CLEAR), then
// the store accepts one write command and one command read per cycle (RUN),
// plus an independent read-only display port addressed by pixel position.
// Optional feature: define RECT_GRID_BORDER_EN to clear the outer ring of
// cells to ROCK instead of NULL; sweep timing is identical either way.
module rect_grid_store
  import rect_grid_pkg::*;
#(
  parameter int GRID_SIZE_X = rect_grid_pkg::GRID_SIZE_X,
  parameter int GRID_SIZE_Y = rect_grid_pkg::GRID_SIZE_Y,
  parameter int RECT_SIZE   = rect_grid_pkg::RECT_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] rect_write,
  input  logic [31:0] rect_read_out,
  output logic [3:0]  rect_read_in,
  input  logic [10:0] vga_hcount,
  input  logic [10:0] vga_vcount,
  output logic [3:0]  cell_func,
  output logic        grid_ready,
  output logic [7:0]  oob_cnt,
  output logic        o_dbg_state
);

  localparam int N  = GRID_SIZE_X * GRID_SIZE_Y;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  // RECT_SIZE is a power of two so the pixel-to-cell divide is a shift.
  localparam int SH = $clog2(RECT_SIZE);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
  localparam logic [31:0]   H_LIM     = 32'(GRID_SIZE_X * RECT_SIZE);
  localparam logic [31:0]   V_LIM     = 32'(GRID_SIZE_Y * RECT_SIZE);

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_sweep_addr;
  logic [3:0]      r_read_in;
  logic [3:0]      r_cell_func;
  logic            r_ready;
  logic [7:0]      r_oob_cnt;
  logic [3:0]      r_mem [N];

  logic            w_wr_in_range;
  logic [AW-1:0]   w_wr_addr;
  logic [3:0]      w_wr_func;
  logic            w_rd_in_range;
  logic [AW-1:0]   w_rd_addr;
  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [3:0]      w_mem_wdata;
  logic [3:0]      w_clear_val;
  logic            w_disp_in_range;
  logic [AW-1:0]   w_disp_addr;

  assign w_wr_func = rect_write[3:0];

  rect_grid_addr #(.GX(GRID_SIZE_X), .GY(GRID_SIZE_Y), .AW(AW)) u_wr_addr (
    .i_x        (rect_write[35:20]),
    .i_y        (rect_write[19:4]),
    .o_in_range (w_wr_in_range),
    .o_addr     (w_wr_addr)
  );

  rect_grid_addr #(.GX(GRID_SIZE_X), .GY(GRID_SIZE_Y), .AW(AW)) u_rd_addr (
    .i_x        (rect_read_out[31:16]),
    .i_y        (rect_read_out[15:0]),
    .o_in_range (w_rd_in_range),
    .o_addr     (w_rd_addr)
  );

`ifdef RECT_GRID_BORDER_EN
  localparam int XW = (GRID_SIZE_X > 1) ? $clog2(GRID_SIZE_X) : 1;
  localparam int YW = (GRID_SIZE_Y > 1) ? $clog2(GRID_SIZE_Y) : 1;
  logic [XW-1:0] r_sweep_x;
  logic [YW-1:0] r_sweep_y;

  // Track the sweep position as x/y alongside the flat address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sweep_x <= '0;
      r_sweep_y <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_sweep_x == XW'(GRID_SIZE_X - 1)) begin
        r_sweep_x <= '0;
        r_sweep_y <= r_sweep_y + 1'b1;
      end else begin
        r_sweep_x <= r_sweep_x + 1'b1;
      end
    end
  end

  assign w_clear_val = ((r_sweep_x == '0) || (r_sweep_x == XW'(GRID_SIZE_X - 1)) ||
                        (r_sweep_y == '0) || (r_sweep_y == YW'(GRID_SIZE_Y - 1)))
                       ? CELL_ROCK : CELL_NULL;
`else
  assign w_clear_val = CELL_NULL;
`endif

  // Display path: pixel to cell by shifting, NULL outside the drawn area.
  assign w_disp_in_range = (32'(vga_hcount) < H_LIM) && (32'(vga_vcount) < V_LIM);
  assign w_disp_addr     = AW'(vga_vcount >> SH) * AW'(GRID_SIZE_X) + AW'(vga_hcount >> SH);

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_CLEAR;
    else      r_state <= w_state_next;
  end

  // Next state and memory write port: sweep writes in CLEAR, commands in RUN.
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_mem_waddr  = w_wr_addr;
    w_mem_wdata  = w_wr_func;
    case (r_state)
      ST_CLEAR: begin
        w_mem_we    = rst;
        w_mem_waddr = r_sweep_addr;
        w_mem_wdata = w_clear_val;
        if (r_sweep_addr == LAST_ADDR) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_mem_we = rst && w_wr_in_range;
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  // Cell storage has no reset; the sweep initializes it.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Sweep counter, ready flag, drop counter and both registered read ports.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sweep_addr <= '0;
      r_read_in    <= CELL_NULL;
      r_cell_func  <= CELL_NULL;
      r_ready      <= 1'b0;
      r_oob_cnt    <= 8'd0;
    end else begin
      r_ready <= (r_state == ST_RUN);
      if (r_state == ST_CLEAR) r_sweep_addr <= r_sweep_addr + 1'b1;
      if ((r_state == ST_RUN) && !w_wr_in_range && (r_oob_cnt != 8'hFF))
        r_oob_cnt <= r_oob_cnt + 8'd1;
      // Command read: out-of-range reads see an implicit wall; a same-cycle
      // write to the same cell is forwarded.
      if (r_state != ST_RUN)
        r_read_in <= CELL_NULL;
      else if (!w_rd_in_range)
        r_read_in <= CELL_ROCK;
      else if (w_mem_we && (w_wr_addr == w_rd_addr))
        r_read_in <= w_wr_func;
      else
        r_read_in <= r_mem[w_rd_addr];
      if ((r_state == ST_RUN) && w_disp_in_range)
        r_cell_func <= r_mem[w_disp_addr];
      else
        r_cell_func <= CELL_NULL;
    end
  end

  assign rect_read_in = r_read_in;
  assign cell_func    = r_cell_func;
  assign grid_ready   = r_ready;
  assign oob_cnt      = r_oob_cnt;
  assign o_dbg_state  = r_state;

endmodule
